mux_rr_nto1: RTL

//  Parametrised N-channel, W-bit registered multiplexer with a valid/ready output stage.
//  Two selection modes: manual select, and round-robin scan over channels that hold valid data.

---
 rtl/mux_rr_nto1.sv | 94 +++++++++
 1 files changed

// File: rtl/mux_rr_nto1.sv
// N-channel, W-bit registered multiplexer with a valid/ready output stage.
// Picks a channel either by manual select or by a round-robin scan over valid channels.
module mux_rr_nto1 #(
  parameter int N = 8,
  parameter int W = 4,
  localparam int SEL_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N*W-1:0]   d_in,
  input  logic [N-1:0]     d_valid,
  output logic [N-1:0]     d_ack,
  input  logic             mode,
  input  logic [SEL_W-1:0] sel,
  output logic [W-1:0]     y,
  output logic [SEL_W-1:0] y_chan,
  output logic             y_valid,
  input  logic             y_ready
);

  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] k;
  logic [W-1:0]     d_k;
  logic             found;
  logic             can_load;
  logic             cap;
  logic [2*N-1:0]   dv_dbl;
  logic [2*N-1:0]   dv_shift;
  logic [N-1:0]     dv_rot;
  int               idx;

  // Round-robin view: dv_rot[i] is channel (ptr+i) mod N; the lowest set bit wins.
  always_comb begin
    found    = 1'b0;
    k        = '0;
    idx      = 0;
    dv_dbl   = {d_valid, d_valid};
    dv_shift = dv_dbl >> ptr;
    dv_rot   = dv_shift[N-1:0];
    if (!mode) begin
      for (int i = 0; i < N; i++) begin
        if (sel == SEL_W'(i) && d_valid[i]) begin
          found = 1'b1;
          k     = SEL_W'(i);
        end
      end
    end else begin
      for (int i = N - 1; i >= 0; i--) begin
        if (dv_rot[i]) begin
          idx = int'(ptr) + i;
          if (idx >= N) idx = idx - N;
          found = 1'b1;
          k     = SEL_W'(idx);
        end
      end
    end
  end

  always_comb begin
    d_k = '0;
    for (int i = 0; i < N; i++) begin
      if (k == SEL_W'(i)) d_k = d_in[i*W +: W];
    end
  end

  assign can_load = !y_valid || y_ready;
  assign cap      = can_load && found;

  always_comb begin
    d_ack = '0;
    for (int i = 0; i < N; i++) begin
      if (cap && k == SEL_W'(i)) d_ack[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y       <= '0;
      y_chan  <= '0;
      y_valid <= 1'b0;
      ptr     <= '0;
    end else begin
      if (cap) begin
        y       <= d_k;
        y_chan  <= k;
        y_valid <= 1'b1;
        if (mode) ptr <= (k == SEL_W'(N - 1)) ? '0 : k + 1'b1;
      end else if (y_valid && y_ready) begin
        y_valid <= 1'b0;
      end
    end
  end

endmodule
